matmul_engine: RTL and testbench

MATMUL_ENGINE -- requirements
Module: matmul_engine

---
 rtl/matmul_engine.sv | 182 ++++++++++++++++++
 tb/tb_matmul_engine.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/matmul_engine.sv
// Sequential N x N matrix multiplier: one MAC per ISSUE/WAIT/MAC triple, one R write per element.
// Strobes, addresses and flags are registered from the next state, so they are glitch-free and reset to 0.
module matmul_engine #(
  parameter int N = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       read_A,
  output logic       read_B,
  output logic [5:0] read_address_A,
  output logic [5:0] read_address_B,
  input  logic [7:0] data_A,
  input  logic [7:0] data_B,
  output logic       write_R,
  output logic [5:0] write_address_R,
  output logic [7:0] write_value_R,
  output logic       busy,
  output logic       done,
  output logic       ovf
);

  // state | meaning
  // IDLE  | waiting for a start rising edge
  // ISSUE | read strobes for A[i][k], B[k][j]
  // WAIT  | memory latency slot
  // MAC   | acc += A*B, step k
  // WRITE | write acc[7:0] to R[i][j]
  // NEXT  | clear acc/k, step j then i
  // DONE  | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_MAC   = 3'd3,
    S_WRITE = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [2:0] NM1 = 3'(N - 1);
  localparam logic [5:0] NW  = 6'(N);

  state_t      state_q, state_d;
  logic        start_q;
  logic [2:0]  i_q, i_d, j_q, j_d, k_q, k_d;
  logic [19:0] acc_q, acc_d;
  logic [15:0] prod;
  logic        accept;

  logic       read_q, read_d, write_q, write_d;
  logic [5:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, waddr_q, waddr_d;
  logic [7:0] wval_q, wval_d;
  logic       busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;

  function automatic logic [5:0] idx(input logic [2:0] row, input logic [2:0] col);
    return {3'b000, row} * NW + {3'b000, col};
  endfunction

  assign prod   = data_A * data_B;
  assign accept = (state_q == S_IDLE) && start && !start_q;

  // start_q resets high so a start already asserted at reset release is not an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b1;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      waddr_q  <= '0;
      wval_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      read_q   <= read_d;
      write_q  <= write_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      waddr_q  <= waddr_d;
      wval_q   <= wval_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ISSUE;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = S_MAC;
      S_MAC: begin
        acc_d = acc_q + {4'b0000, prod};
        if (k_q < NM1) begin
          k_d     = k_q + 3'd1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: state_d = S_NEXT;
      S_NEXT: begin
        acc_d = '0;
        k_d   = '0;
        if (j_q == NM1) begin
          j_d = '0;
          if (i_q == NM1) begin
            state_d = S_DONE;
          end else begin
            i_d     = i_q + 3'd1;
            state_d = S_ISSUE;
          end
        end else begin
          j_d     = j_q + 3'd1;
          state_d = S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    read_d   = (state_d == S_ISSUE);
    write_d  = (state_d == S_WRITE);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    waddr_d  = waddr_q;
    wval_d   = wval_q;
    ovf_d    = ovf_q;
    if (accept) ovf_d = 1'b0;
    if (state_d == S_ISSUE) begin
      addr_a_d = idx(i_d, k_d);
      addr_b_d = idx(k_d, j_d);
    end
    if (state_d == S_WRITE) begin
      waddr_d = idx(i_d, j_d);
      wval_d  = acc_d[7:0];
      if (acc_d[19:8] != '0) ovf_d = 1'b1;
    end
  end

  assign read_A          = read_q;
  assign read_B          = read_q;
  assign read_address_A  = addr_a_q;
  assign read_address_B  = addr_b_q;
  assign write_R         = write_q;
  assign write_address_R = waddr_q;
  assign write_value_R   = wval_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign ovf             = ovf_q;

endmodule

// File: tb/tb_matmul_engine.sv
// Bench for matmul_engine: A/B memory models, expected R writes queued at start and popped on write_R.
module tb_matmul_engine;
  localparam int N = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       read_A, read_B, write_R, busy, done, ovf;
  logic [5:0] read_address_A, read_address_B, write_address_R;
  logic [7:0] data_A = 8'd0, data_B = 8'd0;
  logic [7:0] write_value_R;

  logic [7:0] mem_A [0:63];
  logic [7:0] mem_B [0:63];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  bit log_en = 1'b0;
  int sb[$];
  int la[$];
  int lb[$];

  matmul_engine #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .read_A(read_A), .read_B(read_B),
    .read_address_A(read_address_A), .read_address_B(read_address_B),
    .data_A(data_A), .data_B(data_B),
    .write_R(write_R), .write_address_R(write_address_R), .write_value_R(write_value_R),
    .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (read_A) data_A <= mem_A[read_address_A];
    if (read_B) data_B <= mem_B[read_address_B];
  end

  task automatic check(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int e;
    if (!rst) begin
      if (done) done_cnt++;
      if (read_A != read_B) check("rd_pair", read_B, read_A);
      if (read_A && log_en) begin
        la.push_back(read_address_A);
        lb.push_back(read_address_B);
      end
      if (write_R) begin
        wr_cnt++;
        check("excl", read_A | read_B, 0);
        if (sb.size() == 0) check("extra_wr", 1, 0);
        else begin
          e = sb.pop_front();
          check("wr_addr", write_address_R, e >> 8);
          check("wr_val", write_value_R, e & 255);
        end
      end
    end
  end

  function automatic int push_expected();
    int any_ovf = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int s = 0;
        for (int k = 0; k < N; k++) s += int'(mem_A[i*N+k]) * int'(mem_B[k*N+j]);
        if (s > 255) any_ovf = 1;
        sb.push_back(((i*N + j) << 8) | (s & 255));
      end
    return any_ovf;
  endfunction

  task automatic load(input int a0, a1, a2, a3, b0, b1, b2, b3);
    mem_A[0] = 8'(a0); mem_A[1] = 8'(a1); mem_A[2] = 8'(a2); mem_A[3] = 8'(a3);
    mem_B[0] = 8'(b0); mem_B[1] = 8'(b1); mem_B[2] = 8'(b2); mem_B[3] = 8'(b3);
  endtask

  task automatic do_run(input bit reedge);
    int exp_ovf, w0, d0, t0;
    bit got;
    exp_ovf = push_expected();
    w0 = wr_cnt;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    check("busy_run", busy, 1);
    check("ovf_clr", ovf, 0);
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (reedge && c == 4) start = 1'b0;
      if (reedge && c == 6) start = 1'b1;
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("done_timeout", 0, 1);
    else check("latency", cyc - t0, N*N*(3*N + 2));
    check("ovf", ovf, exp_ovf);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("wr_cnt", wr_cnt - w0, N*N);
    check("done_cnt", done_cnt - d0, 1);
    check("sb_empty", sb.size(), 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    int ea[8] = '{0, 1, 0, 1, 2, 3, 2, 3};
    int eb[8] = '{0, 2, 1, 3, 0, 2, 1, 3};
    int w1;
    bit hit;
    for (int a = 0; a < 64; a++) begin
      mem_A[a] = 8'd0;
      mem_B[a] = 8'd0;
    end

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_strobes", {29'd0, read_A, read_B, write_R}, 0);
    check("rst_addr", {14'd0, read_address_A, read_address_B, write_address_R}, 0);
    check("rst_val", write_value_R, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic product plus read address order
    load(1, 2, 3, 4, 5, 6, 7, 8);
    log_en = 1'b1;
    do_run(1'b0);
    log_en = 1'b0;
    check("addr_seq_len", la.size(), 8);
    for (int n = 0; n < 8 && n < la.size(); n++) begin
      check("addr_A", la[n], ea[n]);
      check("addr_B", lb[n], eb[n]);
    end

    load(1, 0, 0, 1, 9, 8, 7, 6);
    do_run(1'b0);

    load(255, 255, 255, 255, 255, 255, 255, 255);
    do_run(1'b0);
    check("ovf_sticky", ovf, 1);

    load(1, 2, 3, 4, 5, 6, 7, 8);
    do_run(1'b1);

    // reset during the third element's first ISSUE
    load(3, 1, 4, 1, 5, 9, 2, 6);
    w1 = push_expected();
    w1 = wr_cnt;
    @(negedge clk);
    start = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (wr_cnt - w1 == 2 && read_A) begin
        hit = 1'b1;
        break;
      end
    end
    check("reach_issue3", hit, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_strobes", {29'd0, read_A, read_B, write_R}, 0);
    check("arst_flags", {29'd0, busy, done, ovf}, 0);
    check("arst_addr", {14'd0, read_address_A, read_address_B, write_address_R}, 0);
    check("arst_val", write_value_R, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    w1 = wr_cnt;
    repeat (10) @(negedge clk);
    check("no_level_start", busy, 0);
    check("no_wr_after_rst", wr_cnt - w1, 0);
    start = 1'b0;
    @(negedge clk);
    do_run(1'b0);

    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < N*N; a++) begin
        mem_A[a] = 8'($urandom_range(0, 255));
        mem_B[a] = 8'($urandom_range(0, 255));
      end
      do_run(1'b0);
    end
    load(1, 1, 1, 1, 1, 1, 1, 1);
    do_run(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
